// File: rtl/rackctl_cmd_buffer.sv
// Byte-serial RACKctl mode-1 command assembler feeding a command FIFO for the WISHBONE master.
// Optional RACKCTL_CMDBUF_CKSUM_EN appends an XOR checksum byte to every frame.
module rackctl_cmd_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [7:0]            s_tdata_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  output logic [23:0]           cmd_addr_o,
  output logic [31:0]           cmd_data_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ack_i,
  input  logic                  flush_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  frame_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
`ifdef RACKCTL_CMDBUF_CKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
  localparam int         HOLD_W   = 56;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
  localparam int         HOLD_W   = 48;
`endif

  typedef enum logic {
    ST_ASSEMBLE = 1'b0,
    ST_DISCARD  = 1'b1
  } state_t;

  state_t              r_state;
  logic [2:0]          r_bcnt;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_err;
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic [55:0]         r_mem [DEPTH];
`ifdef RACKCTL_CMDBUF_CKSUM_EN
  logic [7:0]          r_cksum;
`endif

  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_last_byte;
  logic                w_frame_ok;
  logic                w_push;
  logic                w_pop;
  logic [55:0]         w_entry;
  logic [55:0]         w_head;

  assign w_count     = r_wptr - r_rptr;
  assign w_full      = (w_count == FULL_CNT);
  assign w_empty     = (w_count == '0);
  assign s_tready_o  = !w_full && !wb_rst_i;
  assign w_accept    = s_tvalid_i && s_tready_o;
  assign w_last_byte = (r_bcnt == LAST_IDX);

`ifdef RACKCTL_CMDBUF_CKSUM_EN
  assign w_entry    = r_hold;
  assign w_frame_ok = (s_tdata_i == r_cksum);
`else
  // The final data byte goes straight into the entry rather than the holding register.
  assign w_entry    = {r_hold, s_tdata_i};
  assign w_frame_ok = 1'b1;
`endif

  assign w_push = w_accept && !flush_i && (r_state == ST_ASSEMBLE) && w_last_byte && w_frame_ok;
  assign w_pop  = cmd_ack_i && !w_empty && !flush_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_ASSEMBLE;
      r_bcnt  <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
`ifdef RACKCTL_CMDBUF_CKSUM_EN
      r_cksum <= '0;
`endif
    end else if (flush_i) begin
      r_state <= ST_ASSEMBLE;
      r_bcnt  <= '0;
      r_err   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_accept) begin
        case (r_state)
          ST_ASSEMBLE: begin
            if (w_last_byte) begin
              r_bcnt <= '0;
              if (!w_frame_ok || !s_tlast_i) r_err <= 1'b1;
              if (!s_tlast_i) r_state <= ST_DISCARD;
            end else if (s_tlast_i) begin
              r_bcnt <= '0;
              r_err  <= 1'b1;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
              r_hold <= {r_hold[HOLD_W-9:0], s_tdata_i};
`ifdef RACKCTL_CMDBUF_CKSUM_EN
              r_cksum <= (r_bcnt == 3'd0) ? s_tdata_i : (r_cksum ^ s_tdata_i);
`endif
            end
          end
          ST_DISCARD: begin
            // Swallow the rest of an overlong frame up to its tlast.
            if (s_tlast_i) begin
              r_state <= ST_ASSEMBLE;
              r_bcnt  <= '0;
            end
          end
          default: r_state <= ST_ASSEMBLE;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= w_entry;
  end

  assign w_head      = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign cmd_valid_o = !w_empty;
  assign cmd_addr_o  = w_empty ? 24'h0 : w_head[55:32];
  assign cmd_data_o  = w_empty ? 32'h0 : w_head[31:0];
  assign count_o     = w_count;
  assign frame_err_o = r_err;

endmodule
